// File: rtl/data_mem_responder.sv
// Data-memory responder: decodes CPU accesses to a word RAM or an MMIO page (GPIO, cycle counter).
// Define DATA_MEM_STORE_BUF_EN to route CPU RAM stores through a forwarding store buffer; otherwise they write the RAM directly.
module data_mem_responder #(
  parameter int ADDR_W   = 10,
  parameter int SB_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      mem_w_en,
  input  logic [31:0]               mem_addr,
  input  logic [31:0]               mem_w_data,
  output logic [31:0]               mem_r_data,
  input  logic                      load_valid,
  output logic                      load_ready,
  input  logic [ADDR_W-1:0]         load_addr,
  input  logic [31:0]               load_data,
  output logic [31:0]               gpio_out,
  output logic [$clog2(SB_DEPTH):0] sb_count
);

  localparam logic [31:0] GPIO_ADDR = 32'hFFFF_FFF0;
  localparam logic [31:0] CNT_ADDR  = 32'hFFFF_FFF4;

  logic [31:0]       ram_mem [2**ADDR_W];
  logic [31:0]       gpio_q, gpio_d;
  logic [31:0]       cycle_q, cycle_d;
  logic              is_gpio, is_cnt, is_ram;
  logic [ADDR_W-1:0] cpu_word;
  logic              cpu_ram_store;
  logic              load_acc;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_wa;
  logic [31:0]       ram_wd;
  logic [31:0]       ram_rd_word;
  logic [31:0]       ram_path_data;

  assign is_gpio       = (mem_addr == GPIO_ADDR);
  assign is_cnt        = (mem_addr == CNT_ADDR);
  assign is_ram        = ~is_gpio & ~is_cnt;
  assign cpu_word      = mem_addr[ADDR_W+1:2];
  assign cpu_ram_store = mem_w_en & is_ram;
  assign ram_rd_word   = ram_mem[cpu_word];

  // MMIO page: identical in both builds
  always_comb begin
    gpio_d  = gpio_q;
    cycle_d = cycle_q + 32'd1;
    if (mem_w_en && is_gpio) gpio_d = mem_w_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gpio_q  <= '0;
      cycle_q <= '0;
    end else begin
      gpio_q  <= gpio_d;
      cycle_q <= cycle_d;
    end
  end

  assign gpio_out = gpio_q;

`ifdef DATA_MEM_STORE_BUF_EN
  localparam int PTR_W = $clog2(SB_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0]   sb_addr_q [SB_DEPTH];
  logic [ADDR_W-1:0]   sb_addr_d [SB_DEPTH];
  logic [31:0]         sb_data_q [SB_DEPTH];
  logic [31:0]         sb_data_d [SB_DEPTH];
  logic [SB_DEPTH-1:0] sb_valid_q, sb_valid_d;
  logic [SB_DEPTH-1:0] load_match;
  logic [PTR_W-1:0]    head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                pop;
  logic                fwd_hit;
  logic [31:0]         fwd_data;
  logic [PTR_W-1:0]    fwd_idx;

  // A full buffer blocks the loader, which in turn guarantees a drain slot for the CPU
  assign load_ready = (count_q < CNT_W'(SB_DEPTH));
  assign load_acc   = load_valid & load_ready;
  assign pop        = (count_q != '0) & ~load_acc;
  assign sb_count   = count_q;

  for (genvar gi = 0; gi < SB_DEPTH; gi++) begin : g_match
    assign load_match[gi] = (sb_addr_q[gi] == load_addr);
  end

  always_comb begin
    sb_addr_d  = sb_addr_q;
    sb_data_d  = sb_data_q;
    sb_valid_d = sb_valid_q;
    if (pop) sb_valid_d[head_q] = 1'b0;
    if (load_acc) sb_valid_d = sb_valid_d & ~load_match;
    // Enqueue last so a same-cycle store survives the loader invalidation
    if (cpu_ram_store) begin
      sb_addr_d[tail_q]  = cpu_word;
      sb_data_d[tail_q]  = mem_w_data;
      sb_valid_d[tail_q] = 1'b1;
    end
    head_d  = head_q + PTR_W'(pop);
    tail_d  = tail_q + PTR_W'(cpu_ram_store);
    count_d = count_q + CNT_W'(cpu_ram_store) - CNT_W'(pop);
  end

  // Walk oldest to youngest so the last hit is the youngest matching store
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    fwd_idx  = '0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      fwd_idx = head_q + PTR_W'(i);
      if ((CNT_W'(i) < count_q) && sb_valid_q[fwd_idx] && (sb_addr_q[fwd_idx] == cpu_word)) begin
        fwd_hit  = 1'b1;
        fwd_data = sb_data_q[fwd_idx];
      end
    end
  end

  assign ram_path_data = fwd_hit ? fwd_data : ram_rd_word;

  always_comb begin
    ram_we = 1'b0;
    ram_wa = load_addr;
    ram_wd = load_data;
    if (load_acc) begin
      ram_we = 1'b1;
    end else if (pop && sb_valid_q[head_q]) begin
      ram_we = 1'b1;
      ram_wa = sb_addr_q[head_q];
      ram_wd = sb_data_q[head_q];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sb_valid_q <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
    end else begin
      sb_valid_q <= sb_valid_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    sb_addr_q <= sb_addr_d;
    sb_data_q <= sb_data_d;
  end
`else
  // CPU store owns the write port; the loader waits
  assign load_ready    = ~cpu_ram_store;
  assign load_acc      = load_valid & load_ready;
  assign sb_count      = '0;
  assign ram_path_data = ram_rd_word;

  always_comb begin
    ram_we = 1'b0;
    ram_wa = load_addr;
    ram_wd = load_data;
    if (cpu_ram_store) begin
      ram_we = 1'b1;
      ram_wa = cpu_word;
      ram_wd = mem_w_data;
    end else if (load_acc) begin
      ram_we = 1'b1;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (ram_we && !rst) ram_mem[ram_wa] <= ram_wd;
  end

  always_comb begin
    mem_r_data = ram_path_data;
    if (is_gpio)     mem_r_data = gpio_q;
    else if (is_cnt) mem_r_data = cycle_q;
  end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

- Responder end of the pipelined CPU's data-memory interface.
- Decodes each CPU store and load address to one of two targets:
  - a word-addressed RAM;
  - a small MMIO page holding a GPIO register and a free-running cycle counter.
- CPU stores pass through a store buffer that drains into the RAM write port.
- A host loader port shares that write port, arbitrated by a valid/ready handshake.
- Sits beside the CPU core. It drives the read data that the CPU samples into its MEM/WB register in the same cycle the address is presented.

## Interface
Parameters:
- ADDR_W, 10: RAM word-address width (RAM depth = 2^ADDR_W words).
- SB_DEPTH, 4: store-buffer entries (power of two, ≥2).

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  rising-edge clock, same as the CPU.
- rst  in  1  asynchronous, active-high reset.
- mem_w_en  in  1  CPU store strobe (the CPU's EX/MEM write enable).
- mem_addr  in  32  CPU byte address (the CPU's EX/MEM ALU result); bits [1:0] ignored.
- mem_w_data  in  32  CPU store data.
- mem_r_data  out  32  combinational read data for mem_addr.
- load_valid  in  1  loader has a word to write.
- load_ready  out  1  loader word accepted at this edge when load_valid=1.
- load_addr  in  ADDR_W  loader word address.
- load_data  in  32  loader data.
- gpio_out  out  32  MMIO GPIO register.
- sb_count  out  $clog2(SB_DEPTH)+1  store-buffer occupancy (debug).

## Operation
Address decode:
- mem_addr == 0xFFFF_FFF0 → GPIO register.
- mem_addr == 0xFFFF_FFF4 → cycle counter (read-only; writes ignored).
- Any other address → RAM word mem_addr[ADDR_W+1:2]. Higher bits alias.

Stores:
- A store to GPIO updates gpio_out at the edge.
- A store to RAM is enqueued at the buffer tail as (word addr, data, valid=1).

Drain:
- Each cycle in which the buffer is non-empty and no loader write is accepted, the head entry is popped.
- If the popped entry is valid, it is written to the RAM.
- An invalidated entry still costs one pop cycle.

Loader:
- load_ready = (count < SB_DEPTH).
- On acceptance the loader word is written directly to the RAM, and drain is blocked that cycle.
- At the same edge, every pending buffer entry with an equal address is invalidated, so the loader wins.
- A CPU store enqueued in that same cycle is not invalidated.

Read path:
- MMIO address → register value.
- RAM address → youngest valid buffer entry with a matching address, else the RAM array word.
- A store presented in the same cycle is not visible; the read returns the pre-edge value.

Other rules:
- Counter: 32-bit, increments every cycle, wraps 0xFFFF_FFFF → 0.
- Full buffer: drain is always allowed when the loader is not ready, so a simultaneous CPU enqueue and drain keeps count at SB_DEPTH. Overflow is impossible by construction.
- Reset values: gpio_out=0, counter=0, sb_count=0, all entries invalid, pointers 0, load_ready=1 after reset release. RAM contents are not reset.
- Reset asserted mid-operation discards pending buffer entries; those stores are lost.

## Timing
- mem_r_data: zero-latency combinational from mem_addr and buffer/RAM state.
- Store enqueue: takes effect at the edge where mem_w_en=1.
  - Forwarded to reads from the next cycle.
  - Reaches the RAM array no earlier than 1 edge later.
- Drain: at most one entry per cycle.
- Loader: one word per accepted edge; load_ready depends only on registered state.
- Counter: the value read in cycle n equals n cycles since reset release, modulo 2^32.

## Configuration
DATA_MEM_STORE_BUF_EN:
- Defined: store buffer, forwarding and sb_count behave as above.
- Undefined:
  - No buffer; CPU RAM stores write the array directly at the edge. sb_count is tied to 0.
  - load_ready = ~(mem_w_en & RAM address), so a CPU store takes priority over the loader.
  - Read path goes to MMIO or the RAM array only.
- MMIO and the counter are identical in both builds.

## Test plan
- Reset, then store 0x1234_5678 to 0x40; load 0x40 the next cycle → 0x1234_5678 from the buffer. Once sb_count returns to 0, the RAM word 16 holds it.
- Hold load_valid=1 while the CPU stores every cycle → sb_count rises to SB_DEPTH and load_ready drops. The CPU keeps storing at count 4 without loss, and every stored word is readable afterwards.
- Buffer holds addr 0x40=0xAAAA_AAAA, then loader writes word 16=0x5555_5555 → after drain completes, reading 0x40 returns 0x5555_5555.
- Store 0x0000_00FF to 0xFFFF_FFF0 → gpio_out=0x0000_00FF next cycle. Store to 0xFFFF_FFF4 → the counter is unaffected.
- Force the counter to 0xFFFF_FFFE (or run 2^32−2 cycles in a short-counter build) → the reads step to 0xFFFF_FFFF, then 0x0000_0000.
- Assert rst mid-burst with 3 pending entries → sb_count=0 and gpio_out=0 immediately. The pending addresses are not written to the RAM.
